// File: rtl/data_mem_lsu.sv
// Byte-addressed RV32I data memory with load/store unit: registered reads,
// byte-enabled writes, error responses and optional two-cycle word-crossing split.
module data_mem_lsu #(
  parameter int          ADDR_BITS        = 17,
  parameter logic [31:0] BASE_ADDR        = 32'h0,
  parameter int          ALLOW_MISALIGNED = 1,
  parameter string       INIT_FILE        = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int IW    = ADDR_BITS - 2;
  localparam int WORDS = 1 << IW;

  typedef enum logic {IDLE, SPLIT} state_t;

  logic [31:0] mem [WORDS];

  state_t      state, state_d;
  logic        accept, f3_ok, range_err, crosses, req_err;
  logic [31:0] off;
  logic [2:0]  size, lane_end;
  logic [32:0] end33;
  logic [7:0]  size_mask, be8;
  logic [63:0] wdata64;
  logic [IW-1:0] word_idx;

  logic [IW-1:0] hi_idx;
  logic [3:0]    hi_be;
  logic [31:0]   hi_data, lo_word;
  logic          hi_we;
  logic [2:0]    sv_f3;
  logic [1:0]    sv_sh;

  logic          wr_en;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data, rd_word, split_word;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign off       = req_addr - BASE_ADDR;
  assign word_idx  = off[ADDR_BITS-1:2];

  always_comb begin
    size      = 3'd4;
    size_mask = 8'h0F;
    case (req_funct3[1:0])
      2'b00: begin size = 3'd1; size_mask = 8'h01; end
      2'b01: begin size = 3'd2; size_mask = 8'h03; end
      default: begin size = 3'd4; size_mask = 8'h0F; end
    endcase
  end

  always_comb begin
    f3_ok = 1'b0;
    if (req_we)
      f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
              (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
  end

  // Last byte offset in 33 bits so an address near 2**32 cannot wrap into range
  assign end33     = {1'b0, off} + {30'b0, size} - 33'd1;
  assign range_err = end33 >= (33'd1 << ADDR_BITS);
  assign lane_end  = {1'b0, off[1:0]} + size - 3'd1;
  assign crosses   = lane_end > 3'd3;
  assign req_err   = !f3_ok || range_err || (crosses && (ALLOW_MISALIGNED == 0));
  assign be8       = size_mask << off[1:0];
  assign wdata64   = {32'b0, req_wdata} << {off[1:0], 3'b000};

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  load_ext = {{24{d[7]}}, d[7:0]};
      3'b001:  load_ext = {{16{d[15]}}, d[15:0]};
      3'b010:  load_ext = d;
      3'b100:  load_ext = {24'b0, d[7:0]};
      3'b101:  load_ext = {16'b0, d[15:0]};
      default: load_ext = 32'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state;
    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_be   = be8[3:0];
    wr_data = wdata64[31:0];
    rd_idx  = word_idx;
    case (state)
      IDLE: begin
        if (accept && !req_err) begin
          wr_en = req_we;
          if (crosses) state_d = SPLIT;
        end
      end
      SPLIT: begin
        state_d = IDLE;
        wr_en   = hi_we;
        wr_idx  = hi_idx;
        wr_be   = hi_be;
        wr_data = hi_data;
        rd_idx  = hi_idx;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_word    = mem[rd_idx];
  assign split_word = 32'({rd_word, lo_word} >> {sv_sh, 3'b000});

  // A write scheduled for the reset edge is dropped, which discards a pending second half
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && crosses) begin
      hi_idx  <= word_idx + IW'(1);
      hi_be   <= be8[7:4];
      hi_data <= wdata64[63:32];
      hi_we   <= req_we;
      sv_f3   <= req_funct3;
      sv_sh   <= off[1:0];
      lo_word <= rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'b0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_d;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'b0;
      if (state == SPLIT) begin
        resp_valid <= 1'b1;
        if (!hi_we) resp_rdata <= load_ext(sv_f3, split_word);
      end else if (accept) begin
        if (req_err) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end else if (!crosses) begin
          resp_valid <= 1'b1;
          if (!req_we) resp_rdata <= load_ext(req_funct3, rd_word >> {off[1:0], 3'b000});
        end
      end
    end
  end

endmodule
